// File: rtl/avalon_burst_ram_slave.sv
// Avalon-MM burst responder over single-port synchronous RAM; reads return 2 cycles after acceptance.
// Optional macro BURST_RAM_WAIT_INJECT_EN adds LFSR-driven waitrequest stalls in IDLE/WRITE.
module avalon_burst_ram_slave #(
  parameter int ADDR_WIDTH     = 32,
  parameter int MEM_WORDS_LOG2 = 12,
  parameter int BURST_WIDTH    = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_WIDTH-1:0]  avs_address,
  input  logic [BURST_WIDTH-1:0] avs_burstcount,
  input  logic                   avs_read,
  input  logic                   avs_write,
  input  logic [31:0]            avs_writedata,
  input  logic [3:0]             avs_byteenable,
  output logic                   avs_waitrequest,
  output logic [31:0]            avs_readdata,
  output logic                   avs_readdatavalid
);

  localparam int DEPTH = 1 << MEM_WORDS_LOG2;
  localparam logic [MEM_WORDS_LOG2-1:0] ADDR_ONE = 1;
  localparam logic [BURST_WIDTH-1:0]    CNT_ONE  = 1;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

  state_t                    state, state_nxt;
  logic [MEM_WORDS_LOG2-1:0] addr_q, addr_nxt, req_idx, mem_addr;
  logic [BURST_WIDTH-1:0]    cnt_q, cnt_nxt, req_cnt;
  logic                      mem_we, mem_re, inject;
  logic [31:0]               mem [DEPTH];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{avs_address[ADDR_WIDTH-1:MEM_WORDS_LOG2+2], avs_address[1:0]};

  assign req_idx = avs_address[MEM_WORDS_LOG2+1:2];
  assign req_cnt = (avs_burstcount == '0) ? CNT_ONE : avs_burstcount;

`ifdef BURST_RAM_WAIT_INJECT_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 8'h01;
    else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign inject = lfsr[0];
`else
  assign inject = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      state  <= state_nxt;
      addr_q <= addr_nxt;
      cnt_q  <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    addr_nxt        = addr_q;
    cnt_nxt         = cnt_q;
    mem_we          = 1'b0;
    mem_re          = 1'b0;
    mem_addr        = addr_q;
    avs_waitrequest = 1'b0;
    case (state)
      S_IDLE: begin
        avs_waitrequest = inject;
        if (!inject) begin
          // Simultaneous read and write resolves as a write.
          if (avs_write) begin
            mem_we   = 1'b1;
            mem_addr = req_idx;
            if (req_cnt > CNT_ONE) begin
              addr_nxt  = req_idx + ADDR_ONE;
              cnt_nxt   = req_cnt - CNT_ONE;
              state_nxt = S_WRITE;
            end
          end else if (avs_read) begin
            addr_nxt  = req_idx;
            cnt_nxt   = req_cnt;
            state_nxt = S_READ;
          end
        end
      end
      S_WRITE: begin
        avs_waitrequest = inject;
        if (!inject && avs_write) begin
          mem_we   = 1'b1;
          addr_nxt = addr_q + ADDR_ONE;
          cnt_nxt  = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_nxt = S_IDLE;
        end
      end
      S_READ: begin
        avs_waitrequest = 1'b1;
        mem_re          = 1'b1;
        addr_nxt        = addr_q + ADDR_ONE;
        cnt_nxt         = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (avs_byteenable[b]) mem[mem_addr][8*b +: 8] <= avs_writedata[8*b +: 8];
      end
    end
  end

  // Registered RAM output doubles as the readdata port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdatavalid <= mem_re;
      if (mem_re) avs_readdata <= mem[addr_q];
    end
  end

endmodule

// File: tb/tb_avalon_burst_ram_slave.sv
// Randomized self-checking bench for avalon_burst_ram_slave against a word/byte memory model.
module tb_avalon_burst_ram_slave;

  localparam int DEPTH = 4096;
`ifdef BURST_RAM_WAIT_INJECT_EN
  localparam bit INJ = 1'b1;
`else
  localparam bit INJ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] avs_address = '0;
  logic [6:0]  avs_burstcount = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [3:0]  avs_byteenable = '0;
  logic        avs_waitrequest;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;

  avalon_burst_ram_slave dut (
    .clk(clk), .rst_n(rst_n), .avs_address(avs_address), .avs_burstcount(avs_burstcount),
    .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_byteenable(avs_byteenable), .avs_waitrequest(avs_waitrequest),
    .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int          rv_cyc[$];
  logic [31:0] rv_dat[$];
  always @(negedge clk) begin
    if (avs_readdatavalid === 1'b1) begin
      rv_cyc.push_back(cyc);
      rv_dat.push_back(avs_readdata);
    end
  end

  // Reference memory: data plus per-byte "has been written" flags.
  logic [31:0] mdl [DEPTH];
  logic [3:0]  kb  [DEPTH];
  logic [31:0] wd  [64];
  logic [3:0]  wb  [64];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] mask_of(input logic [3:0] k);
    return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
  endfunction

  // Called at a negedge with the request driven; returns at the negedge after acceptance.
  task automatic accept_cycle(output int acc, output int stalls);
    int guard = 0;
    stalls = 0;
    while (avs_waitrequest !== 1'b0 && guard < 200) begin
      stalls++;
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout waitrequest=%b required 0", avs_waitrequest);
    end
    acc = cyc;
    @(negedge clk);
  endtask

  task automatic write_burst(input logic [31:0] addr, input int bc, input int nbeats,
                             input bit bubbles, output int stalls_total);
    int acc, st, w;
    int idx = int'(addr[13:2]);
    stalls_total = 0;
    for (int i = 0; i < nbeats; i++) begin
      if (bubbles && i > 0) begin
        avs_write = 1'b0;
        avs_writedata = $urandom;
        @(negedge clk);
      end
      avs_write      = 1'b1;
      avs_writedata  = wd[i];
      avs_byteenable = wb[i];
      if (i == 0) begin
        avs_address    = addr;
        avs_burstcount = 7'(bc);
      end else begin
        avs_address    = $urandom;
        avs_burstcount = 7'($urandom);
      end
      accept_cycle(acc, st);
      stalls_total += st;
      w = (idx + i) % DEPTH;
      for (int b = 0; b < 4; b++) begin
        if (wb[i][b]) begin
          mdl[w][8*b +: 8] = wd[i][8*b +: 8];
          kb[w][b] = 1'b1;
        end
      end
    end
    avs_write = 1'b0;
  endtask

  task automatic issue_read(input logic [31:0] addr, input int bc, output int acc);
    int st;
    avs_read       = 1'b1;
    avs_address    = addr;
    avs_burstcount = 7'(bc);
    accept_cycle(acc, st);
    avs_read = 1'b0;
  endtask

  task automatic collect(input logic [31:0] addr, input int n, input int acc, input string name);
    int guard = 0;
    int idx = int'(addr[13:2]);
    int c, w;
    logic [31:0] d, m;
    while (rv_cyc.size() < n && guard < n + 20) begin
      @(negedge clk);
      guard++;
    end
    if (rv_cyc.size() < n) begin
      n_checks++; n_fail++;
      $display("FAIL %s_valid_count got=%0d required=%0d", name, rv_cyc.size(), n);
      rv_cyc.delete(); rv_dat.delete();
      return;
    end
    for (int i = 0; i < n; i++) begin
      c = rv_cyc.pop_front();
      d = rv_dat.pop_front();
      w = (idx + i) % DEPTH;
      m = mask_of(kb[w]);
      n_checks++;
      if (c !== acc + 2 + i) begin
        n_fail++;
        $display("FAIL %s_timing beat=%0d cycle=%0d required=%0d", name, i, c, acc + 2 + i);
      end
      n_checks++;
      if ((d & m) !== (mdl[w] & m)) begin
        n_fail++;
        $display("FAIL %s_data beat=%0d word=%0d got=%h required=%h mask=%h", name, i, w, d, mdl[w], m);
      end
    end
  endtask

  task automatic check_quiet(input string name);
    repeat (4) @(negedge clk);
    n_checks++;
    if (rv_cyc.size() != 0) begin
      n_fail++;
      $display("FAIL %s_extra_valids got=%0d required=0", name, rv_cyc.size());
      rv_cyc.delete(); rv_dat.delete();
    end
  endtask

  task automatic read_check(input logic [31:0] addr, input int bc, input string name);
    int acc;
    issue_read(addr, bc, acc);
    collect(addr, (bc == 0) ? 1 : bc, acc, name);
    check_quiet(name);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (avs_readdatavalid !== 1'b0) begin
      n_fail++; $display("FAIL reset_rdv got=%b required=0", avs_readdatavalid);
    end
    n_checks++;
    if (avs_readdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata got=%h required=0", avs_readdata);
    end
    n_checks++;
    if (avs_waitrequest !== INJ) begin
      n_fail++; $display("FAIL reset_wait got=%b required=%b", avs_waitrequest, INJ);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_burst16();
    int st;
    for (int i = 0; i < 16; i++) begin wd[i] = 32'hA0 + i; wb[i] = 4'hF; end
    write_burst(32'h100, 16, 16, 1'b0, st);
    n_checks++;
    if (INJ ? (st == 0) : (st != 0)) begin
      n_fail++; $display("FAIL burst16_write_stalls got=%0d inject=%b", st, INJ);
    end
    read_check(32'h100, 16, "burst16");
  endtask

  task automatic test_byteenable();
    int st;
    wd[0] = 32'h11223344; wb[0] = 4'hF;
    write_burst(32'h200, 1, 1, 1'b0, st);
    wd[0] = 32'hFFFFFFFF; wb[0] = 4'b0101;
    write_burst(32'h200, 1, 1, 1'b0, st);
    n_checks++;
    if (mdl[128] !== 32'h11FF33FF) begin
      n_fail++; $display("FAIL be_model got=%h required=11ff33ff", mdl[128]);
    end
    read_check(32'h200, 1, "byteenable");
    // byteenable 0000 still consumes a beat
    wd[0] = 32'h0; wb[0] = 4'h0; wd[1] = 32'hCAFEF00D; wb[1] = 4'hF;
    write_burst(32'h200, 2, 2, 1'b0, st);
    read_check(32'h200, 2, "be_zero");
  endtask

  task automatic test_wrap();
    int st;
    for (int i = 0; i < 4; i++) begin wd[i] = i + 1; wb[i] = 4'hF; end
    write_burst(32'h3FF8, 4, 4, 1'b0, st);
    read_check(32'h3FF8, 4, "wrap");
    read_check(32'h0, 2, "wrap_low");
  endtask

  task automatic test_bubbles();
    int st;
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; wb[i] = 4'hF; end
    write_burst(32'h400, 4, 4, 1'b1, st);
    read_check(32'h400, 4, "bubbles");
  endtask

  task automatic test_back_to_back();
    int acc_a, acc_b;
    issue_read(32'h100, 4, acc_a);
    issue_read(32'h3FF8, 3, acc_b);
    n_checks++;
    if (INJ ? (acc_b < acc_a + 5) : (acc_b != acc_a + 5)) begin
      n_fail++; $display("FAIL b2b_accept cycle=%0d required=%0d", acc_b, acc_a + 5);
    end
    collect(32'h100, 4, acc_a, "b2b_a");
    collect(32'h3FF8, 3, acc_b, "b2b_b");
    check_quiet("b2b");
    read_check(32'h104, 0, "bc_zero");
  endtask

  task automatic test_random();
    int st, bc, addr;
    for (int it = 0; it < 8; it++) begin
      addr = $urandom;
      bc = $urandom_range(1, 12);
      for (int i = 0; i < bc; i++) begin wd[i] = $urandom; wb[i] = 4'($urandom); end
      write_burst(addr, bc, bc, 1'($urandom), st);
      read_check(addr, $urandom_range(0, 12), "rand");
    end
  endtask

  task automatic test_reset_mid_read();
    int acc, guard;
    issue_read(32'h100, 8, acc);
    guard = 0;
    while (rv_cyc.size() < 3 && guard < 20) begin @(negedge clk); guard++; end
    n_checks++;
    if (rv_cyc.size() < 3) begin
      n_fail++; $display("FAIL rstrd_pre_valids got=%0d required=3", rv_cyc.size());
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (avs_readdatavalid !== 1'b0) begin
      n_fail++; $display("FAIL rstrd_async_rdv got=%b required=0", avs_readdatavalid);
    end
    rv_cyc.delete(); rv_dat.delete();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (avs_waitrequest !== INJ) begin
      n_fail++; $display("FAIL rstrd_wait got=%b required=%b", avs_waitrequest, INJ);
    end
    repeat (10) @(negedge clk);
    check_quiet("rstrd");
  endtask

  task automatic test_reset_mid_write();
    int st;
    for (int i = 0; i < 8; i++) begin wd[i] = 32'h5500 + i; wb[i] = 4'hF; end
    write_burst(32'h800, 8, 3, 1'b0, st);
    #1 rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    read_check(32'h800, 3, "rstwr");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin mdl[i] = '0; kb[i] = '0; end
    test_reset();
    test_burst16();
    test_byteenable();
    test_wrap();
    test_bubbles();
    test_back_to_back();
    test_random();
    test_reset_mid_read();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
